// File: rtl/uart_time_msg.sv
// Snapshots BCD time on request and streams it as ASCII "HH:MM:SS" through a tx_en/din/tx_busy handshake.
// Define UART_TIME_MSG_CRLF_EN to append CR LF to every message.
module uart_time_msg #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] din,
    output logic       msg_busy,
    output logic       msg_done,
    output logic       msg_err
);

    // state | meaning
    // IDLE  | no message in flight; starts one on send or pending
    // REQ   | tx_en high, waiting for the transmitter to accept the byte
    // WAIT  | byte accepted, waiting for tx_busy to fall

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

`ifdef UART_TIME_MSG_CRLF_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif

    state_t      state;
    logic        pending;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic [23:0] snap;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [23:0] t);
        case (i)
            4'd0:       return digit(t[23:20]);
            4'd1:       return digit(t[19:16]);
            4'd2, 4'd5: return 8'h3A;
            4'd3:       return digit(t[15:12]);
            4'd4:       return digit(t[11:8]);
            4'd6:       return digit(t[7:4]);
            4'd7:       return digit(t[3:0]);
`ifdef UART_TIME_MSG_CRLF_EN
            4'd8:       return 8'h0D;
            4'd9:       return 8'h0A;
`endif
            default:    return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            idx      <= 4'd0;
            cnt      <= 16'd0;
            snap     <= 24'd0;
            tx_en    <= 1'b0;
            din      <= 8'h00;
            msg_busy <= 1'b0;
            msg_done <= 1'b0;
            msg_err  <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            msg_err  <= 1'b0;
            // Requests arriving mid-message merge into a single queued restart.
            if (send && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (send || pending) begin
                        snap     <= {hour_bcd, min_bcd, sec_bcd};
                        pending  <= 1'b0;
                        idx      <= 4'd0;
                        cnt      <= 16'd0;
                        din      <= msg_byte(4'd0, {hour_bcd, min_bcd, sec_bcd});
                        tx_en    <= 1'b1;
                        msg_busy <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (tx_busy) begin
                        tx_en <= 1'b0;
                        cnt   <= 16'd0;
                        state <= WAIT;
                    end else if (cnt == TIMEOUT - 16'd1) begin
                        tx_en    <= 1'b0;
                        msg_err  <= 1'b1;
                        cnt      <= 16'd0;
                        msg_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (idx == LAST) begin
                            msg_done <= 1'b1;
                            msg_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            din   <= msg_byte(idx + 4'd1, snap);
                            tx_en <= 1'b1;
                            cnt   <= 16'd0;
                            state <= REQ;
                        end
                    end
                end
                default: begin
                    tx_en    <= 1'b0;
                    msg_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_time_msg.sv
// Randomized bench for uart_time_msg against a queue-based message model and a simple transmitter model.
module tb_uart_time_msg;

`ifdef UART_TIME_MSG_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] hour_bcd = 8'h00;
    logic [7:0] min_bcd = 8'h00;
    logic [7:0] sec_bcd = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_en;
    logic [7:0] din;
    logic       msg_busy;
    logic       msg_done;
    logic       msg_err;

    uart_time_msg #(.TIMEOUT(16'd16)) dut (
        .clk(clk), .rst(rst), .send(send),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .tx_busy(tx_busy), .tx_en(tx_en), .din(din),
        .msg_busy(msg_busy), .msg_done(msg_done), .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    // transmitter model: busy after lat cycles of tx_en, held for hold cycles
    bit xmit_on = 1'b1;
    int lat = 2, hold = 20;
    int lat_cnt = 0, hold_cnt = 0;

    always @(negedge clk) begin
        if (!rst || !xmit_on) begin
            tx_busy = 1'b0; lat_cnt = 0; hold_cnt = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) tx_busy = 1'b0;
        end else if (tx_en) begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
                tx_busy = 1'b1; hold_cnt = hold; lat_cnt = 0;
            end
        end
    end

    // monitor
    logic [7:0] got_q[$];
    int done_cnt = 0, err_cnt = 0, din_viol = 0;
    int en_cur = 0, en_last = 0, low_run = 0, last_gap = 0;
    logic prev_en = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_din = 8'h00;

    always @(negedge clk) begin
        if (tx_en && !prev_en) got_q.push_back(din);
        if (rst && prev_rst && din != prev_din && !(tx_en && !prev_en)) din_viol++;
        if (msg_done) done_cnt++;
        if (msg_err) err_cnt++;
        if (tx_en) en_cur++;
        else begin
            if (en_cur > 0) en_last = en_cur;
            en_cur = 0;
        end
        if (!msg_busy) low_run++;
        else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
        prev_en = tx_en; prev_din = din; prev_rst = rst;
    end

    // reference model: expected byte stream built from the time values
    logic [7:0] exp_q[$];

    function automatic logic [7:0] ascii_digit(input int v);
        return (v < 10) ? 8'(48 + v) : 8'h3F;
    endfunction

    task automatic expect_msg(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        int t[3];
        t[0] = int'(h); t[1] = int'(m); t[2] = int'(s);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) exp_q.push_back(8'h3A);
            exp_q.push_back(ascii_digit(t[k] / 16));
            exp_q.push_back(ascii_digit(t[k] % 16));
        end
        if (CRLF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic compare_bytes(input string tag, input int base);
        check({tag, "_len"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++)
            check($sformatf("%s_b%0d", tag, k), 32'(got_q[base + k]), 32'(exp_q[k]));
        exp_q.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_level(input int len);
        tick();
        send = 1'b1;
        repeat (len) tick();
        send = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 3000) begin
            tick();
            n++;
            if (!msg_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check({tag, "_hang"}, 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int count);
        int n = 0;
        while (got_q.size() < count && n < 2000) begin
            tick();
            n++;
        end
        if (got_q.size() < count) check({tag, "_nobytes"}, 32'(got_q.size()), 32'(count));
    endtask

    initial begin
        int base, d0, e0, n, len;
        logic [7:0] h, m, s;

        // reset state
        repeat (3) tick();
        check("reset_outs", {22'd0, tx_en, din, msg_busy, msg_done, msg_err}, 32'd0);
        rst = 1'b1;
        tick();

        // 12:34:56, latency of first byte
        hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
        base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
        tick();
        send = 1'b1;
        @(posedge clk);
        #1;
        check("lat_tx_en", 32'(tx_en), 32'd1);
        check("lat_din", 32'(din), 32'h31);
        check("lat_busy", 32'(msg_busy), 32'd1);
        send = 1'b0;
        expect_msg(8'h12, 8'h34, 8'h56);
        wait_quiet("basic");
        compare_bytes("basic", base);
        check("basic_done", 32'(done_cnt - d0), 32'd1);
        check("basic_err", 32'(err_cnt - e0), 32'd0);

        // invalid nibble and mid-message input change
        sec_bcd = 8'h5C;
        base = got_q.size(); d0 = done_cnt;
        send_level(1);
        wait_bytes("snap", base + 1);
        hour_bcd = 8'h23;
        expect_msg(8'h12, 8'h34, 8'h5C);
        wait_quiet("snap");
        compare_bytes("snap", base);
        check("snap_done", 32'(done_cnt - d0), 32'd1);

        // two requests during a message merge into one restart with a fresh snapshot
        hour_bcd = 8'h01; min_bcd = 8'h02; sec_bcd = 8'h03;
        base = got_q.size(); d0 = done_cnt;
        send_level(1);
        wait_bytes("pend", base + 2);
        send_level(1);
        wait_bytes("pend", base + 4);
        send_level(1);
        hour_bcd = 8'h21; min_bcd = 8'h43; sec_bcd = 8'h09;
        expect_msg(8'h01, 8'h02, 8'h03);
        expect_msg(8'h21, 8'h43, 8'h09);
        wait_quiet("pend");
        compare_bytes("pend", base);
        check("pend_done", 32'(done_cnt - d0), 32'd2);
        check("pend_gap", 32'(last_gap), 32'd1);

        // timeout with transmitter silent
        xmit_on = 1'b0;
        hour_bcd = 8'h07;
        base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
        send_level(1);
        n = 0;
        while (err_cnt == e0 && n < 100) begin tick(); n++; end
        check("to_seen", 32'(err_cnt - e0), 32'd1);
        check("to_en_len", 32'(en_last), 32'd16);
        check("to_outs", {30'd0, tx_en, msg_busy}, 32'd0);
        wait_quiet("to");
        exp_q.push_back(8'h30);
        compare_bytes("to", base);
        check("to_done", 32'(done_cnt - d0), 32'd0);
        check("to_err", 32'(err_cnt - e0), 32'd1);

        // pending request survives a timeout abort
        base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
        send_level(1);
        repeat (4) tick();
        send_level(1);
        n = 0;
        while (err_cnt == e0 && n < 100) begin tick(); n++; end
        xmit_on = 1'b1;
        exp_q.push_back(8'h30);
        expect_msg(8'h07, 8'h43, 8'h09);
        wait_quiet("to_pend");
        compare_bytes("to_pend", base);
        check("to_pend_done", 32'(done_cnt - d0), 32'd1);
        check("to_pend_err", 32'(err_cnt - e0), 32'd1);

        // asynchronous reset during byte 4
        hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
        lat = 2; hold = 20;
        base = got_q.size();
        send_level(1);
        wait_bytes("rst", base + 4);
        n = 0;
        while (!(tx_busy && !tx_en) && n < 100) begin tick(); n++; end
        #2 rst = 1'b0;
        #1 check("rst_outs", {22'd0, tx_en, din, msg_busy, msg_done, msg_err}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        base = got_q.size();
        repeat (5) tick();
        check("rst_idle", {31'd0, msg_busy}, 32'd0);
        check("rst_nobyte", 32'(got_q.size() - base), 32'd0);
        d0 = done_cnt;
        send_level(1);
        expect_msg(8'h12, 8'h34, 8'h56);
        wait_quiet("rst");
        compare_bytes("rst", base);
        check("rst_done", 32'(done_cnt - d0), 32'd1);

        // randomized messages; a send held over several edges queues one extra message
        for (int it = 0; it < 8; it++) begin
            h = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            s = 8'($urandom_range(0, 255));
            lat = $urandom_range(1, 4);
            hold = $urandom_range(1, 25);
            len = $urandom_range(1, 3);
            hour_bcd = h; min_bcd = m; sec_bcd = s;
            base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
            send_level(len);
            expect_msg(h, m, s);
            if (len > 1) expect_msg(h, m, s);
            wait_quiet($sformatf("rnd%0d", it));
            compare_bytes($sformatf("rnd%0d", it), base);
            check($sformatf("rnd%0d_done", it), 32'(done_cnt - d0), (len > 1) ? 32'd2 : 32'd1);
            check($sformatf("rnd%0d_err", it), 32'(err_cnt - e0), 32'd0);
        end

        check("din_stable", 32'(din_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
